// File: rtl/q15_stopwatch.sv
// Millisecond/second/minute stopwatch with IDLE/RUN/PAUSED control and a 1 ms prescaler.
// Optional Q15_SATURATE_EN: freeze at 59:59.999 instead of wrapping to 00:00.000.
module q15_stopwatch #(
  parameter int unsigned TICKS_PER_MS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic [9:0] millisec,
  output logic [5:0] sec,
  output logic [5:0] min
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

  localparam logic [15:0] PreMax = 16'(TICKS_PER_MS - 1);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [9:0]  ms_q, ms_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic        tick;
  logic        at_max;

  assign at_max = (ms_q == 10'd999) && (sec_q == 6'd59) && (min_q == 6'd59);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    min_d   = min_q;
    tick    = 1'b0;

    unique case (state_q)
      StIdle:   if (start && !stop) state_d = StRun;
      StRun:    if (stop) state_d = StPaused;
      StPaused: if (start && !stop) state_d = StRun;
      default:  state_d = StIdle;
    endcase

    // The prescaler advances on the registered RUN state, so the stop-sampling edge still counts.
    if (state_q == StRun) begin
      if (presc_q == PreMax) begin
        presc_d = 16'd0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

`ifdef Q15_SATURATE_EN
    if (tick && !at_max) begin
`else
    if (tick) begin
`endif
      if (ms_q == 10'd999) begin
        ms_d = 10'd0;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= 16'd0;
      ms_q    <= 10'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
    end
  end

  assign millisec = ms_q;
  assign sec      = sec_q;
  assign min      = min_q;

endmodule

// File: tb/tb_q15_stopwatch.sv
// Randomized and directed bench for q15_stopwatch with a total-milliseconds reference model.
module tb_q15_stopwatch;

  localparam int Wrap = 3600000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [9:0] ms0, ms1;
  logic [5:0] s0, s1, m0, m1;

  int total_n = 0;
  int bad_n   = 0;

  // Model: state 0=idle 1=run 2=paused; elapsed time held as a single millisecond count.
  int m_state [2];
  int m_presc [2];
  int m_total [2];
  int tpm     [2] = '{1, 3};
  int preload_cnt  = 0;
  int preload_seen = 0;

  always #5 clk = ~clk;

  q15_stopwatch #(.TICKS_PER_MS(1)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .millisec (ms0),
    .sec      (s0),
    .min      (m0)
  );

  q15_stopwatch #(.TICKS_PER_MS(3)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .millisec (ms1),
    .sec      (s1),
    .min      (m1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_ms(input int t);
    return t % 1000;
  endfunction

  function automatic int exp_s(input int t);
    return (t / 1000) % 60;
  endfunction

  function automatic int exp_m(input int t);
    return (t / 60000) % 60;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0;
        m_presc[i] = 0;
        m_total[i] = 0;
      end
    end else begin
      if (preload_cnt != preload_seen) begin
        preload_seen = preload_cnt;
        for (int i = 0; i < 2; i++) m_total[i] = Wrap - 1;
      end
      for (int i = 0; i < 2; i++) begin
        automatic bit t = 1'b0;
        if (m_state[i] == 1) begin
          if (m_presc[i] == tpm[i] - 1) begin
            m_presc[i] = 0;
            t = 1'b1;
          end else begin
            m_presc[i] = m_presc[i] + 1;
          end
        end
        if (t) begin
`ifdef Q15_SATURATE_EN
          if (m_total[i] < Wrap - 1) m_total[i] = m_total[i] + 1;
`else
          m_total[i] = (m_total[i] + 1) % Wrap;
`endif
        end
        if (m_state[i] == 0 && start && !stop) m_state[i] = 1;
        else if (m_state[i] == 1 && stop) m_state[i] = 2;
        else if (m_state[i] == 2 && start && !stop) m_state[i] = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("ms0", int'(ms0), exp_ms(m_total[0]));
    chk("sec0", int'(s0), exp_s(m_total[0]));
    chk("min0", int'(m0), exp_m(m_total[0]));
    chk("ms1", int'(ms1), exp_ms(m_total[1]));
    chk("sec1", int'(s1), exp_s(m_total[1]));
    chk("min1", int'(m1), exp_m(m_total[1]));
  end

  // Called at a falling edge; holds the inputs for n rising edges and returns at a falling edge.
  task automatic run(input logic s, input logic p, input int n);
    start = s;
    stop  = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_time(input string name, input int mn, input int sc, input int ms,
                          input int which);
    if (which == 0) begin
      chk({name, "_min"}, int'(m0), mn);
      chk({name, "_sec"}, int'(s0), sc);
      chk({name, "_ms"}, int'(ms0), ms);
    end else begin
      chk({name, "_min"}, int'(m1), mn);
      chk({name, "_sec"}, int'(s1), sc);
      chk({name, "_ms"}, int'(ms1), ms);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);
    chk_time("reset0", 0, 0, 0, 0);
    chk_time("reset1", 0, 0, 0, 1);
    reset = 1'b0;

    run(1'b1, 1'b0, 1000);
    run(1'b0, 1'b1, 1);
    chk_time("first_sec", 0, 1, 0, 0);
    run(1'b0, 1'b1, 4999);
    chk_time("stop_hold", 0, 1, 0, 0);
    run(1'b0, 1'b0, 1000);
    chk_time("idle_hold", 0, 1, 0, 0);
    chk_time("presc3_a", 0, 0, 333, 1);

    run(1'b1, 1'b0, 4000);
    run(1'b0, 1'b1, 1);
    chk_time("five_sec", 0, 5, 0, 0);
    chk_time("presc3_b", 0, 1, 666, 1);
    run(1'b0, 1'b1, 100);
    chk_time("frozen", 0, 5, 0, 0);

    reset = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0, 0);
    run(1'b0, 1'b0, 2);
    reset = 1'b0;
    run(1'b1, 1'b1, 50);
    chk_time("both_high", 0, 0, 0, 0);
    run(1'b0, 1'b0, 5);
    chk_time("still_idle", 0, 0, 0, 0);

    for (int seg = 0; seg < 150; seg++) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) begin
        #2 reset = 1'b1;
        #1;
        chk_time("rnd_rst0", 0, 0, 0, 0);
        chk_time("rnd_rst1", 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
      end
    end

    reset = 1'b1;
    run(1'b0, 1'b0, 1);
    reset = 1'b0;
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 2);
    force dut0.ms_q  = 10'd999;
    force dut0.sec_q = 6'd59;
    force dut0.min_q = 6'd59;
    force dut1.ms_q  = 10'd999;
    force dut1.sec_q = 6'd59;
    force dut1.min_q = 6'd59;
    preload_cnt++;
    #1;
    release dut0.ms_q;
    release dut0.sec_q;
    release dut0.min_q;
    release dut1.ms_q;
    release dut1.sec_q;
    release dut1.min_q;
    @(negedge clk);
`ifdef Q15_SATURATE_EN
    chk_time("top_tick", 59, 59, 999, 0);
    run(1'b0, 1'b0, 5);
    chk_time("top_hold", 59, 59, 999, 0);
`else
    chk_time("top_tick", 0, 0, 0, 0);
    run(1'b0, 1'b0, 5);
    chk_time("after_wrap", 0, 0, 5, 0);
`endif

    run(1'b0, 1'b0, 10);
    #2 reset = 1'b1;
    #1;
    chk_time("midrun_rst0", 0, 0, 0, 0);
    chk_time("midrun_rst1", 0, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    run(1'b0, 1'b0, 20);
    chk_time("post_rst0", 0, 0, 0, 0);
    chk_time("post_rst1", 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/q15_stopwatch.md
Q15_STOPWATCH -- requirements
Module: q15_stopwatch

Interface
REQ-001 SHALL declare parameter TICKS_PER_MS, default 1: clock cycles per millisecond count; legal range 1 to 65535.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  level request to run the stopwatch.
REQ-005 SHALL provide port stop  input  1  level request to pause the stopwatch.
REQ-006 SHALL provide port millisec  output  10  milliseconds digit, 0-999.
REQ-007 SHALL provide port sec  output  6  seconds digit, 0-59.
REQ-008 SHALL provide port min  output  6  minutes digit, 0-59.

Function
REQ-009 SHALL implement a registered FSM with states IDLE, RUN and PAUSED.
REQ-010 SHALL transition as follows, evaluated each rising edge:
- IDLE -> RUN when start=1 and stop=0.
- RUN -> PAUSED when stop=1.
- PAUSED -> RUN when start=1 and stop=0.
- Otherwise hold state; start=stop=0 holds RUN or PAUSED.
REQ-011 SHALL give stop priority over start when both are 1.
REQ-012 SHALL use an internal prescaler 0..TICKS_PER_MS-1:
- Advances only on edges where the registered state is RUN.
- Emits a 1 ms tick on wrap.
- Holds its value in IDLE and PAUSED.
REQ-013 SHALL, on each tick, increment millisec; at 999 -> 0 with carry to sec; sec 59 -> 0 with carry to min.
REQ-014 SHALL, without Q15_SATURATE_EN, wrap 59:59.999 -> 00:00.000 on the next tick.
REQ-015 SHALL, in IDLE and PAUSED, hold millisec, sec and min unchanged.
REQ-016 SHALL have, with TICKS_PER_MS=1, start sampled at edge N giving millisec=1 after edge N+1.
REQ-017 SHALL, for the edge that samples stop=1 while in RUN, still count that edge, because the registered state is RUN; counting stops from the next edge.
REQ-018 SHALL drive all outputs directly from registers, with no combinational path from start or stop.
REQ-019 SHALL never present out-of-range values: millisec>999 or sec/min>59.

Reset
REQ-020 SHALL, when reset=1, immediately force state=IDLE, prescaler=0, millisec=0, sec=0 and min=0, regardless of clk.
REQ-021 SHALL abort counting when reset asserts mid-RUN; after release, the block stays in IDLE until start is sampled.
REQ-022 SHALL ignore start and stop while reset=1.

Configuration
REQ-023 SHALL support macro Q15_SATURATE_EN:
- When defined, the count freezes at 59:59.999 and the state stays RUN until stop or reset.
- When undefined, REQ-014 wrap applies.

Verification
REQ-024 SHALL cover these directed scenarios, with TICKS_PER_MS=1 and a 1 ms clock:
- Reset, then start=1 held for 1000 edges after the sampling edge -> min=0, sec=1, millisec=0.
- stop=1, start=0 for 5000 cycles, then both low for 1000 cycles -> outputs unchanged at 00:01.000.
- start=1 again for 4000 counting edges -> 00:05.000; then stop=1 -> frozen.
- start=1 and stop=1 together from IDLE -> remains 00:00.000.
- Preload to 59:59.999 and one tick -> 00:00.000, or with Q15_SATURATE_EN, 59:59.999 held.
- Assert reset mid-RUN between edges -> all outputs 0 at once; start=0 after release -> stays 0.
